path_mailbox: RTL and testbench

- CPU-side responder for the path-request handshake.
- The sequencer holds cpu_reset high while presenting SP/EP. This block latches them and exposes them to the RISC-V core as memory-mapped registers.
- It collects the path nodes the core writes, and raises cpu_done when the core writes the DONE register.
- Sits between the core data bus and the sequencer, one per CPU instance.

---
 rtl/path_mailbox.sv | 118 +++++++++++
 tb/tb_path_mailbox.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/path_mailbox.sv
// path_mailbox: memory-mapped mailbox between the path sequencer and a RISC-V core.
// Latches SP/EP during reset, collects the pushed path nodes and flags completion.
module path_mailbox #(
    parameter logic [31:0] MMIO_BASE = 32'h0200_0000,
    parameter int          MAX_PATH  = 32,
    parameter int          NODE_W    = 8
) (
    input  logic                        clk_50M,
    input  logic                        cpu_reset,
    input  logic [NODE_W-1:0]           SP,
    input  logic [NODE_W-1:0]           EP,
    input  logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_wdata,
    input  logic                        mem_we,
    input  logic                        mem_re,
    output logic [31:0]                 mem_rdata,
    output logic                        cpu_done,
    output logic [$clog2(MAX_PATH):0]   path_len,
    input  logic [$clog2(MAX_PATH)-1:0] path_idx,
    output logic [NODE_W-1:0]           path_node,
    output logic                        path_ovf
);
    localparam int AW = $clog2(MAX_PATH);
    localparam int LW = AW + 1;

    localparam logic [3:0] OFF_SP    = 4'h0;
    localparam logic [3:0] OFF_EP    = 4'h1;
    localparam logic [3:0] OFF_STAT  = 4'h2;
    localparam logic [3:0] OFF_CLEAR = 4'h3;
    localparam logic [3:0] OFF_PUSH  = 4'h4;
    localparam logic [3:0] OFF_DONE  = 4'h5;

    typedef enum logic [1:0] {REQ, RUN, DONE} state_t;

    state_t            state;
    logic [NODE_W-1:0] sp_q;
    logic [NODE_W-1:0] ep_q;
    logic [NODE_W-1:0] nodes [MAX_PATH];

    logic        hit;
    logic [3:0]  off;
    logic        full;
    logic        bus_wr;
    logic        push_ok;
    logic [7:0]  len8;
    logic [31:0] status;
    logic [31:0] rd_val;
    logic        unused;

    assign hit     = mem_addr[31:6] == MMIO_BASE[31:6];
    assign off     = mem_addr[5:2];
    assign full    = path_len == LW'(MAX_PATH);
    assign bus_wr  = mem_we && hit && state == RUN;
    assign push_ok = bus_wr && off == OFF_PUSH && !full;
    assign len8    = 8'(path_len);
    assign status  = {16'd0, len8, 5'd0, path_ovf, cpu_done, state == RUN};
    assign unused  = ^{mem_addr[1:0], mem_wdata};

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (off)
                OFF_SP:   rd_val = 32'(sp_q);
                OFF_EP:   rd_val = 32'(ep_q);
                OFF_STAT: rd_val = status;
                default:  rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (cpu_reset) begin
            state     <= REQ;
            sp_q      <= SP;
            ep_q      <= EP;
            path_len  <= '0;
            path_ovf  <= 1'b0;
            cpu_done  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            // Read samples pre-write state, so a same-cycle write is not visible.
            if (mem_re)
                mem_rdata <= (state == REQ) ? '0 : rd_val;
            unique case (state)
                REQ: state <= RUN;
                RUN: begin
                    if (mem_we && hit) begin
                        case (off)
                            OFF_CLEAR: if (mem_wdata[0]) begin
                                path_len <= '0;
                                path_ovf <= 1'b0;
                            end
                            OFF_PUSH: begin
                                if (full) path_ovf <= 1'b1;
                                else      path_len <= path_len + LW'(1);
                            end
                            OFF_DONE: if (mem_wdata[0]) begin
                                state    <= DONE;
                                cpu_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: ;
                default: state <= REQ;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!cpu_reset && push_ok)
            nodes[path_len[AW-1:0]] <= mem_wdata[NODE_W-1:0];
    end

    assign path_node = (path_len == '0) ? '0 : nodes[path_idx];

endmodule

// File: tb/tb_path_mailbox.sv
// tb_path_mailbox: vector table, corner sequences and random traffic
// compared against a queue-based model of the mailbox.
module tb_path_mailbox;
    localparam logic [31:0] B    = 32'h0200_0000;
    localparam int          MAXP = 32;

    logic        clk = 1'b0;
    logic        cpu_reset;
    logic [7:0]  SP, EP;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata;
    logic        cpu_done;
    logic [5:0]  path_len;
    logic [4:0]  path_idx;
    logic [7:0]  path_node;
    logic        path_ovf;

    always #10 clk = ~clk;

    path_mailbox #(.MMIO_BASE(B), .MAX_PATH(MAXP), .NODE_W(8)) dut (
        .clk_50M(clk), .cpu_reset(cpu_reset), .SP(SP), .EP(EP),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .cpu_done(cpu_done),
        .path_len(path_len), .path_idx(path_idx), .path_node(path_node),
        .path_ovf(path_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of nodes plus a mode flag.
    typedef enum {M_REQ, M_RUN, M_DONE} mmode_t;
    mmode_t      m_mode = M_REQ;
    logic [7:0]  q[$];
    bit          m_done = 0, m_ovf = 0;
    logic [7:0]  m_sp = 0, m_ep = 0;
    logic [31:0] m_rdata = 0;

    function automatic logic [31:0] rd_model(input int off);
        case (off)
            0: return {24'd0, m_sp};
            1: return {24'd0, m_ep};
            2: return {16'd0, 8'(q.size()), 5'd0, m_ovf, m_done, m_mode == M_RUN};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model(input bit r, input logic [7:0] s, e,
                         input logic [31:0] a, wd, input bit w, rd);
        bit hit;
        int off;
        hit = a[31:6] == B[31:6];
        off = int'(a[5:2]);
        if (r) begin
            m_mode = M_REQ; q.delete(); m_done = 0; m_ovf = 0;
            m_sp = s; m_ep = e; m_rdata = 0;
        end else if (m_mode == M_REQ) begin
            if (rd) m_rdata = 0;
            m_mode = M_RUN;
        end else begin
            if (rd) m_rdata = hit ? rd_model(off) : 32'd0;
            if (w && hit && m_mode == M_RUN) begin
                if (off == 3 && wd[0]) begin
                    q.delete(); m_ovf = 0;
                end else if (off == 4) begin
                    if (q.size() < MAXP) q.push_back(wd[7:0]);
                    else m_ovf = 1;
                end else if (off == 5 && wd[0]) begin
                    m_mode = M_DONE; m_done = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input logic [7:0] s, e, input logic [31:0] a, wd,
                        input bit w, rd, input logic [4:0] idx);
        @(negedge clk);
        cpu_reset = r; SP = s; EP = e; mem_addr = a; mem_wdata = wd;
        mem_we = w; mem_re = rd; path_idx = idx;
        model(r, s, e, a, wd, w, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] idx);
        step(0, 0, 0, 0, 0, 0, 0, idx);
    endtask

    typedef struct {
        bit rst; logic [7:0] sp, ep; logic [31:0] addr, wd; bit we, re; logic [4:0] idx;
        logic [31:0] rdata; bit done; int len; bit ovf; logic [7:0] node;
    } vec_t;
    vec_t tv[$];

    function automatic void add(bit r, logic [7:0] s, e, logic [31:0] a, wd, bit w, rd,
                                logic [4:0] idx, logic [31:0] x_rd, bit x_done, int x_len,
                                bit x_ovf, logic [7:0] x_node);
        vec_t v;
        v.rst = r; v.sp = s; v.ep = e; v.addr = a; v.wd = wd; v.we = w; v.re = rd;
        v.idx = idx; v.rdata = x_rd; v.done = x_done; v.len = x_len; v.ovf = x_ovf;
        v.node = x_node;
        tv.push_back(v);
    endfunction

    initial begin
        cpu_reset = 1; SP = 0; EP = 0; mem_addr = 0; mem_wdata = 0;
        mem_we = 0; mem_re = 0; path_idx = 0;

        //  rst sp  ep  addr              wd            we re idx  rdata     dn len ovf node
        add(1,  5, 21, 0,                0,            0, 0, 0,   0,        0, 0, 0, 0);
        add(1,  5, 21, 0,                0,            0, 0, 0,   0,        0, 0, 0, 0);
        add(0,  5, 21, B,                0,            0, 1, 0,   0,        0, 0, 0, 0);
        add(0,  5, 21, B,                0,            0, 1, 0,   5,        0, 0, 0, 0);
        add(0,  5, 21, B + 4,            0,            0, 1, 0,   21,       0, 0, 0, 0);
        add(0,  5, 21, B + 8,            0,            0, 1, 0,   1,        0, 0, 0, 0);
        add(0,  5, 21, B + 'h10,         7,            1, 0, 0,   1,        0, 1, 0, 7);
        add(0,  5, 21, B + 'h10,         3,            1, 0, 1,   1,        0, 2, 0, 3);
        add(0,  5, 21, B + 'h10,         21,           1, 0, 2,   1,        0, 3, 0, 21);
        add(0,  5, 21, B + 8,            0,            0, 1, 0,   'h301,    0, 3, 0, 7);
        add(0,  5, 21, B + 'h14,         1,            1, 0, 1,   'h301,    1, 3, 0, 3);
        add(0,  5, 21, B + 8,            0,            0, 1, 2,   'h302,    1, 3, 0, 21);
        add(0,  5, 21, B + 'h10,         9,            1, 0, 0,   'h302,    1, 3, 0, 7);
        add(0,  5, 21, B + 'h0C,         1,            1, 0, 1,   'h302,    1, 3, 0, 3);
        add(1,  0,  7, 0,                0,            0, 0, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B,                0,            0, 1, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B,                0,            0, 1, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B + 4,            0,            0, 1, 0,   7,        0, 0, 0, 0);
        add(0,  0,  7, B + 'h3C,         0,            0, 1, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B + 8,            0,            0, 1, 0,   1,        0, 0, 0, 0);
        add(0,  0,  7, 32'h1000_0000,    0,            0, 1, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B + 'h3C,         32'hFFFF_FFFF, 1, 0, 0,  0,        0, 0, 0, 0);
        add(0,  0,  7, 32'h1000_0010,    5,            1, 0, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, 32'h1000_0014,    1,            1, 0, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B + 8,            0,            0, 1, 0,   1,        0, 0, 0, 0);
        add(1,  0,  7, B + 'h10,         9,            1, 0, 0,   0,        0, 0, 0, 0);
        add(1,  0,  7, B + 'h10,         9,            1, 0, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B + 'h10,         9,            1, 0, 0,   0,        0, 0, 0, 0);
        add(0,  0,  7, B + 8,            0,            0, 1, 0,   1,        0, 0, 0, 0);
        add(0,  0,  7, B + 'h10,         'h44,         1, 1, 0,   0,        0, 1, 0, 'h44);
        add(0,  0,  7, B + 'h0B,         0,            0, 1, 0,   'h101,    0, 1, 0, 'h44);

        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].sp, tv[i].ep, tv[i].addr, tv[i].wd,
                 tv[i].we, tv[i].re, tv[i].idx);
            chk($sformatf("v%0d_rdata", i), mem_rdata, tv[i].rdata);
            chk($sformatf("v%0d_done", i), 32'(cpu_done), 32'(tv[i].done));
            chk($sformatf("v%0d_len", i), 32'(path_len), 32'(tv[i].len));
            chk($sformatf("v%0d_ovf", i), 32'(path_ovf), 32'(tv[i].ovf));
            chk($sformatf("v%0d_node", i), 32'(path_node), 32'(tv[i].node));
        end

        // Overflow: 33 pushes into a 32-entry buffer, then CLEAR.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        for (int i = 0; i < MAXP + 1; i++)
            step(0, 0, 0, B + 'h10, 32'(i * 7 + 1), 1, 0, 5'd31);
        chk("ovf_len", 32'(path_len), 32);
        chk("ovf_flag", 32'(path_ovf), 1);
        chk("ovf_node31", 32'(path_node), 32'd218);
        step(0, 0, 0, B + 8, 0, 0, 1, 0);
        chk("ovf_status", mem_rdata, 32'h0000_2005);
        chk("ovf_node0", 32'(path_node), 1);
        step(0, 0, 0, B + 'h0C, 1, 1, 0, 0);
        chk("clr_len", 32'(path_len), 0);
        chk("clr_ovf", 32'(path_ovf), 0);
        chk("clr_node", 32'(path_node), 0);

        // Abort in the middle of RUN.
        step(0, 0, 0, B + 'h10, 11, 1, 0, 0);
        step(0, 0, 0, B + 'h10, 12, 1, 0, 0);
        chk("abort_pre_len", 32'(path_len), 2);
        step(1, 9, 4, 0, 0, 0, 0, 0);
        chk("abort_len", 32'(path_len), 0);
        chk("abort_done", 32'(cpu_done), 0);
        idle(0);
        step(0, 0, 0, B + 8, 0, 0, 1, 0);
        chk("abort_status", mem_rdata, 32'h0000_0001);
        step(0, 0, 0, B, 0, 0, 1, 0);
        chk("abort_sp", mem_rdata, 9);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          r, w, rd;
            int          k, off;
            logic [31:0] a;
            logic [4:0]  idx;
            r = $urandom_range(0, 99) < 2;
            k = $urandom_range(0, 99);
            if (k < 40)      off = 4;
            else if (k < 55) off = 2;
            else if (k < 65) off = $urandom_range(0, 1);
            else if (k < 68) off = 3;
            else if (k < 70) off = 5;
            else             off = $urandom_range(0, 15);
            a = B | 32'(off << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            w   = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            idx = 5'($urandom_range(0, 31));
            step(r, 8'($urandom), 8'($urandom), a, $urandom, w, rd, idx);
            chk("rnd_rdata", mem_rdata, m_rdata);
            chk("rnd_done", 32'(cpu_done), 32'(m_done));
            chk("rnd_len", 32'(path_len), 32'(q.size()));
            chk("rnd_ovf", 32'(path_ovf), 32'(m_ovf));
            if (q.size() == 0)
                chk("rnd_node_empty", 32'(path_node), 0);
            else if (int'(idx) < q.size())
                chk("rnd_node", 32'(path_node), 32'(q[idx]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
